axi_arbiter: RTL

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_arbiter.sv
// rtl/axi_arbiter.sv - IFU/LSU to single AXI master arbiter (optional round-robin read arbitration: AXI_ARB_RR_EN)
module axi_arbiter #(
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64,
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] LSU_ID = 4'd1
) (
    input  logic                clock,
    input  logic                reset,
    // fetch read port
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_ack,
    output logic [DATA_W-1:0]   ifu_rdata,
    // load port
    input  logic                lsu_rreq,
    input  logic [ADDR_W-1:0]   lsu_raddr,
    output logic                lsu_rack,
    output logic [DATA_W-1:0]   lsu_rdata,
    // store port
    input  logic                lsu_wreq,
    input  logic [ADDR_W-1:0]   lsu_waddr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_wack,
    // AXI AR / R
    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    output logic                rready,
    // AXI AW / W / B
    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic                owner_lsu;
    logic [ADDR_W-1:0]   araddr_q;
    logic [3:0]          arid_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [3:0]          awid_q;
    logic                aw_done;
    logic                w_done;

    logic lsu_elig;
    logic pick_lsu;
    logic pick_ifu;
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

`ifdef AXI_ARB_RR_EN
    logic last_lsu;
`endif

    // Loads wait for any in-flight or pending store to keep load-after-store ordering.
    always_comb begin
        lsu_elig = lsu_rreq && (w_state == W_IDLE) && !lsu_wreq;
`ifdef AXI_ARB_RR_EN
        pick_lsu = lsu_elig && (!ifu_req || !last_lsu);
`else
        pick_lsu = lsu_elig;
`endif
        pick_ifu = ifu_req && !pick_lsu;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (pick_lsu || pick_ifu) r_next = R_AR;
            R_AR:   if (arready) r_next = R_DATA;
            R_DATA: if (rvalid) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_lsu <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
        end else if (r_state == R_IDLE && (pick_lsu || pick_ifu)) begin
            owner_lsu <= pick_lsu;
            araddr_q  <= pick_lsu ? lsu_raddr : ifu_addr;
            arid_q    <= pick_lsu ? LSU_ID : IFU_ID;
        end
    end

`ifdef AXI_ARB_RR_EN
    // Reset value points at LSU so the first contested grant goes to IFU.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu <= 1'b1;
        end else if (r_state == R_IDLE && (pick_lsu || pick_ifu)) begin
            last_lsu <= pick_lsu;
        end
    end
`endif

    assign arvalid   = (r_state == R_AR);
    assign araddr    = araddr_q;
    assign arid      = arid_q;
    assign rready    = (r_state == R_DATA);
    assign ifu_ack   = (r_state == R_DATA) && rvalid && !owner_lsu;
    assign lsu_rack  = (r_state == R_DATA) && rvalid && owner_lsu;
    assign ifu_rdata = ifu_ack  ? rdata : '0;
    assign lsu_rdata = lsu_rack ? rdata : '0;

    // AW and W complete independently; the done flags remember whichever finished first.
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done || w_hs;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (lsu_wreq) w_next = W_ADDR;
            W_ADDR: if (aw_fin && w_fin) w_next = W_RESP;
            W_RESP: if (bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            awid_q   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (lsu_wreq) begin
                        awaddr_q <= lsu_waddr;
                        wdata_q  <= lsu_wdata;
                        wstrb_q  <= lsu_wstrb;
                        awid_q   <= LSU_ID;
                    end
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                default: begin
                    aw_done <= aw_done;
                    w_done  <= w_done;
                end
            endcase
        end
    end

    assign awvalid  = (w_state == W_ADDR) && !aw_done;
    assign wvalid   = (w_state == W_ADDR) && !w_done;
    assign awaddr   = awaddr_q;
    assign awid     = awid_q;
    assign wdata    = wdata_q;
    assign wstrb    = wstrb_q;
    assign bready   = (w_state == W_RESP);
    assign lsu_wack = (w_state == W_RESP) && bvalid;

endmodule
